// File: rtl/nic_pkg.sv
// nic_pkg: shared constants for the queued NIC.
//   - Processor register map (2-bit addr select).
//   - Packet field positions for the default 64-bit packet.
//   - Processor access request struct.
package nic_pkg;

    localparam int DATA_W_DEF = 64;

    // Packet fields (64-bit packet)
    localparam int VC_BIT  = 63;
    localparam int HOP_HI  = 55;
    localparam int HOP_LO  = 48;
    localparam int PAY_HI  = 31;
    localparam int PAY_LO  = 0;

    // Processor register map
    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    typedef struct packed {
        logic       en;
        logic       wr;
        logic [1:0] addr;
    } cpu_req_t;

endpackage

// File: rtl/nic_sync_fifo.sv
// nic_sync_fifo: DEPTH-entry synchronous FIFO, show-ahead head output.
// Ports:
//   clk, rst (sync, active-low)
//   push/din   : write, ignored when full
//   pop/dout   : read, ignored when empty; dout is the current head
//   full/empty : derived from the registered count
//   count      : occupancy 0..DEPTH
module nic_sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // full/empty come from registered state, so a same-cycle pop never
    // frees room for a push (and a same-cycle push never feeds a pop).
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nic_queued.sv
// nic_queued: processor <-> router NIC with DEPTH-deep input/output FIFOs.
// Ports:
//   clk, rst (sync, active-low)
//   addr/d_in/nicEN/nicWrEn : processor access; d_out registered read data
//   net_polarity            : router phase, gates injection by VC bit
//   net_so/net_ro/net_do    : injection toward router (valid/ready/data)
//   net_si/net_ri/net_di    : ejection from router (valid/ready/data)
// Config macro: NIC_STATUS_COUNT_EN -- status words carry FIFO occupancy
//   in bits [CNT_W:1]; otherwise those bits read 0.
module nic_queued
    import nic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              nicEN,
    input  logic              nicWrEn,
    output logic [DATA_W-1:0] d_out,
    input  logic              net_polarity,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di
);

    cpu_req_t          req;
    logic              rd_acc, wr_acc;

    logic [DATA_W-1:0] in_head, out_head;
    logic              in_full, in_empty, out_full, out_empty;
    logic [CNT_W-1:0]  in_cnt, out_cnt;
    logic              in_push, in_pop, out_push, out_pop;
    logic [DATA_W-1:0] in_stat, out_stat;

    assign req    = '{en: nicEN, wr: nicWrEn, addr: addr};
    assign rd_acc = req.en && !req.wr;
    assign wr_acc = req.en && req.wr;

    // Handshakes are forced low during reset so nothing transfers on a
    // reset cycle and the router sees no stale valid.
    assign net_ri   = rst && !in_full;
    assign net_so   = rst && !out_empty && (out_head[DATA_W-1] == net_polarity);
    assign net_do   = out_head;

    assign in_push  = net_si && net_ri;
    assign in_pop   = rd_acc && (req.addr == ADDR_IN_DATA);
    // A full output FIFO drops the write even if the router pops this cycle.
    assign out_push = wr_acc && (req.addr == ADDR_OUT_DATA) && !out_full;
    assign out_pop  = net_so && net_ro;

    nic_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push),
        .din   (net_di),
        .pop   (in_pop),
        .dout  (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_cnt)
    );

    nic_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_push),
        .din   (d_in),
        .pop   (out_pop),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_cnt)
    );

    // Status words reflect state before this cycle's access/handshake.
    always_comb begin
        in_stat     = '0;
        out_stat    = '0;
        in_stat[0]  = (in_cnt != '0);
        out_stat[0] = (out_cnt == CNT_W'(DEPTH));
`ifdef NIC_STATUS_COUNT_EN
        in_stat[CNT_W:1]  = in_cnt;
        out_stat[CNT_W:1] = out_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_out <= '0;
        end else if (rd_acc) begin
            case (req.addr)
                ADDR_IN_DATA:  d_out <= in_empty ? '0 : in_head;
                ADDR_IN_STAT:  d_out <= in_stat;
                ADDR_OUT_STAT: d_out <= out_stat;
                default:       d_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_queued.sv
module tb_nic_queued;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic        nicEN, nicWrEn;
    logic [63:0] d_out;
    logic        net_polarity;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    int checks = 0;
    int errors = 0;

`ifdef NIC_STATUS_COUNT_EN
    localparam logic [63:0] ST_FULL4 = 64'h9;  // bit0=1, count 4
    localparam logic [63:0] ST_IN2   = 64'h5;  // non-empty, count 2
    localparam logic [63:0] ST_OUT2  = 64'h4;  // not full, count 2
`else
    localparam logic [63:0] ST_FULL4 = 64'h1;
    localparam logic [63:0] ST_IN2   = 64'h1;
    localparam logic [63:0] ST_OUT2  = 64'h0;
`endif

    always #5 clk = ~clk;

    nic_queued dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .d_in         (d_in),
        .nicEN        (nicEN),
        .nicWrEn      (nicWrEn),
        .d_out        (d_out),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [63:0] d);
        addr = a; d_in = d; nicEN = 1'b1; nicWrEn = 1'b1;
        tick();
        nicEN = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic cpu_rd(input logic [1:0] a);
        addr = a; nicEN = 1'b1; nicWrEn = 1'b0;
        tick();
        nicEN = 1'b0;
    endtask

    logic [63:0] a_pk [5];
    logic [63:0] b_pk [5];

    initial begin
        for (int i = 0; i < 5; i++) begin
            a_pk[i] = 64'h0000_0000_0000_1000 + 64'(i);
            b_pk[i] = 64'h0011_0000_BEEF_0000 + 64'(i);
        end
        rst = 1'b0; addr = 2'b00; d_in = '0; nicEN = 1'b0; nicWrEn = 1'b0;
        net_polarity = 1'b0; net_ro = 1'b0; net_si = 1'b1; net_di = 64'hDEAD;

        // Reset held 3 cycles with a router valid pending
        repeat (3) tick();
        chk("rst_dout", d_out, 64'h0);
        chk("rst_so", net_so, 1'b0);
        chk("rst_ri", net_ri, 1'b0);
        rst = 1'b1; net_si = 1'b0;
        tick();
        chk("post_rst_ri", net_ri, 1'b1);
        cpu_rd(2'b01);
        chk("post_rst_istat", d_out, 64'h0);

        // Fill output FIFO, 5th write dropped
        for (int i = 0; i < 5; i++) cpu_wr(2'b10, a_pk[i]);
        cpu_rd(2'b11);
        chk("out_full_stat", d_out, ST_FULL4);
        cpu_rd(2'b10);
        chk("rd_out_data_zero", d_out, 64'h0);
        chk("fill_so", net_so, 1'b1);
        net_ro = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_do%0d", i), net_do, a_pk[i]);
            tick();
        end
        net_ro = 1'b0;
        chk("drain_empty_so", net_so, 1'b0);
        cpu_rd(2'b11);
        chk("drain_stat", d_out, 64'h0);

        // Polarity gating
        cpu_wr(2'b10, 64'h8000_0000_FFFF_0002);
        chk("pol0_so", net_so, 1'b0);
        net_ro = 1'b1;
        tick();
        chk("pol0_hold_so", net_so, 1'b0);
        net_polarity = 1'b1;
        #1;
        chk("pol1_so", net_so, 1'b1);
        chk("pol1_do", net_do, 64'h8000_0000_FFFF_0002);
        tick();
        chk("pol1_popped", net_so, 1'b0);
        net_ro = 1'b0; net_polarity = 1'b0;

        // Ejection backpressure
        net_si = 1'b1;
        for (int i = 0; i < 4; i++) begin
            net_di = b_pk[i];
            tick();
        end
        net_di = b_pk[4];
        chk("ej_full_ri", net_ri, 1'b0);
        tick();
        chk("ej_hold_ri", net_ri, 1'b0);
        cpu_rd(2'b01);
        chk("ej_full_stat", d_out, ST_FULL4);
        cpu_rd(2'b00);
        chk("ej_rd0", d_out, b_pk[0]);
        chk("ej_room_ri", net_ri, 1'b1);
        tick();
        net_si = 1'b0;
        chk("ej_refull_ri", net_ri, 1'b0);
        for (int i = 1; i < 5; i++) begin
            cpu_rd(2'b00);
            chk($sformatf("ej_rd%0d", i), d_out, b_pk[i]);
        end

        // Empty read
        cpu_rd(2'b00);
        chk("empty_rd", d_out, 64'h0);
        cpu_rd(2'b01);
        chk("empty_stat", d_out, 64'h0);
        chk("empty_ri", net_ri, 1'b1);

        // Mid-traffic reset: two packets queued each side
        cpu_wr(2'b10, 64'h8000_0000_0000_00A1);
        cpu_wr(2'b10, 64'h8000_0000_0000_00A2);
        net_si = 1'b1;
        net_di = 64'h0000_0000_0000_00C1; tick();
        net_di = 64'h0000_0000_0000_00C2; tick();
        net_si = 1'b0;
        cpu_rd(2'b01);
        chk("mid_istat", d_out, ST_IN2);
        cpu_rd(2'b11);
        chk("mid_ostat", d_out, ST_OUT2);
        cpu_rd(2'b00);
        chk("mid_rd", d_out, 64'h0000_0000_0000_00C1);
        rst = 1'b0;
        net_polarity = 1'b1; net_ro = 1'b1;
        tick();
        chk("mid_rst_dout", d_out, 64'h0);
        chk("mid_rst_so", net_so, 1'b0);
        chk("mid_rst_ri", net_ri, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid_stale_so%0d", i), net_so, 1'b0);
        end
        net_ro = 1'b0;
        cpu_rd(2'b01);
        chk("mid_post_istat", d_out, 64'h0);
        cpu_rd(2'b11);
        chk("mid_post_ostat", d_out, 64'h0);
        cpu_rd(2'b00);
        chk("mid_post_rd", d_out, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nic_queued.md
# nic_queued

Parametrised network interface controller between one processing element and its ring/mesh router port. Successor to the single-entry-buffer NIC: the input and output channels are DEPTH-deep FIFOs with ready/valid router handshakes, virtual-channel (VC) polarity gating on injection, and optional occupancy reporting. Instantiated once per node inside the interconnect top level.

## Interface

- DATA_W, 64, packet width; bit DATA_W-1 is the VC bit.
- DEPTH, 4, entries per FIFO (≥2, power of two).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- addr  in  2  register select: 00 input data, 01 input status, 10 output data, 11 output status.
- d_in  in  DATA_W  processor write data.
- nicEN  in  1  processor access enable.
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEN).
- d_out  out  DATA_W  registered processor read data.
- net_polarity  in  1  router phase; selects which VC may inject this cycle.
- net_so  out  1  output packet valid toward router.
- net_ro  in  1  router ready for output packet.
- net_do  out  DATA_W  output packet (head of output FIFO).
- net_si  in  1  incoming packet valid from router.
- net_ri  out  1  NIC ready to accept incoming packet.
- net_di  in  DATA_W  incoming packet.

## Operation

- Processor write, addr 10: push d_in into output FIFO if not full; dropped if full (even if router pops the same cycle).
- Processor write to 00/01/11: ignored.
- Processor read, addr 00: if input FIFO non-empty, d_out <= head and pop; if empty, d_out <= 0, no pop.
- Read 01: d_out <= input status; bit 0 = input non-empty.
- Read 11: d_out <= output status; bit 0 = output full.
- Read 10: d_out <= 0.
- nicEN = 0: no access, d_out holds.
- Injection: net_so = output non-empty AND head[DATA_W-1] == net_polarity. net_do = head (combinational from storage). Transfer when net_so && net_ro at the edge -> pop.
- Ejection: net_ri = input FIFO not full. Transfer when net_si && net_ri -> push net_di.
- Input FIFO simultaneous push and pop: both occur; count unchanged. A full FIFO never accepts a push (net_ri derived from the registered count, not the same-cycle pop).
- Packets are never reordered or modified. Pointers wrap modulo DEPTH.

## Timing

- Reset (rst low at an edge): FIFOs empty, pointers/counts 0, d_out = 0. net_so = 0 and net_ri = 0 while rst is low; net_ri = 1 on the first cycle after release.
- Reset mid-operation: all queued packets discarded; no handshake completes on a reset cycle.
- Read latency: 1 cycle (d_out valid the cycle after the access edge).
- Write-to-inject: a pushed packet can assert net_so the following cycle, gated by polarity.
- Ejection-to-visible: a packet accepted at edge N is readable by an addr-00 access at edge N+1.
- Status reflects state before the same-cycle access/handshake.

## Configuration

- NIC_STATUS_COUNT_EN defined: status words also carry occupancy in bits [CNT_W:1] (input count for 01, output count for 11); bit 0 unchanged.
- Undefined: bits DATA_W-1:1 of status words are 0; no count exported.

## Structure

- Package nic_pkg: address constants (ADDR_IN_DATA, ADDR_IN_STAT, ADDR_OUT_DATA, ADDR_OUT_STAT), field positions (VC bit 63, hop field 55:48, payload 31:0), default DATA_W.
- Sub-module nic_sync_fifo (DATA_W, DEPTH): push/pop/full/empty/count; two instances.

## Test plan

- Reset: rst low 3 cycles -> d_out = 0, net_so = 0, net_ri = 0; after release net_ri = 1, status 01 read returns 0.
- Fill output: 5 writes to addr 10 with net_ro = 0, DEPTH = 4 -> 4 stored, 5th dropped, status 11 bit 0 = 1; with COUNT_EN, bits [3:1] = 4.
- Polarity gating: head 64'h8000_0000_FFFF_0002 (VC = 1), net_polarity = 0 -> net_so = 0; polarity = 1, net_ro = 1 -> net_so = 1, pop in one cycle, net_do = that word.
- Ejection backpressure: push 4 packets from router -> net_ri = 0; 5th net_si held; one addr-00 read -> net_ri = 1 next cycle, 5th accepted, read order preserved.
- Empty read: addr 00 read on empty input -> d_out = 0, no underflow; subsequent status 01 = 0.
- Mid-traffic reset: 2 packets queued each side, rst low 1 cycle -> all counts 0, d_out = 0, no stale packet injected afterwards.
